adam_clk_div_prog: RTL and testbench
====================================

# adam_clk_div_prog

Runtime-programmable, multi-channel clock divider for the ADAM peripheral/clock subsystem. It generalises the fixed-ratio divider to `CHANNELS` independent outputs, each with a `WIDTH`-bit divisor written over a valid/ready port and a per-channel enable. Divisor changes and disables take effect only on a period boundary, so no output ever produces a truncated phase. Outputs are registered divided clocks plus one-cycle rising-edge ticks, intended as clock enables for downstream logic.

## Interface
- `WIDTH`, 8: divisor width; half-period = D+1 cycles, D in [0, 2^WIDTH-1].
- `CHANNELS`, 2: number of independent output channels (>= 1).
- `RST_DIV`, 0: active and pending divisor value of every channel after reset.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `div_valid`  in  1  divisor write request.
- `div_ready`  out  1  write can be accepted for channel `div_chan`.
- `div_chan`  in  CW  target channel; CW = `CHANNELS`>1 ? $clog2(`CHANNELS`) : 1.
- `div_value`  in  `WIDTH`  new divisor D.
- `en`  in  `CHANNELS`  per-channel run enable.
- `clk_out`  out  `CHANNELS`  divided clocks, registered.
- `tick`  out  `CHANNELS`  one-cycle pulse coincident with each `clk_out` 0->1.

## Operation
- Per channel: `active` divisor, `pending` value + `pend` flag, counter `cnt` (WIDTH bits), state IDLE or RUN.
- Write accepted when `div_valid && div_ready`; stores `div_value` to `pending`, sets `pend`. `div_ready` = !`pend[div_chan]`. `div_chan` >= `CHANNELS`: `div_ready`=1, write accepted and discarded.
- IDLE: `clk_out`=0, `cnt`=0. If `pend`: `active`<=`pending`, `pend` cleared (next edge). If `en`=1: go RUN, `clk_out`<=1, `tick`<=1, `cnt`<=0; a pending value is applied on the same edge and used for this period.
- RUN, each edge: `cnt`==`active` -> `cnt`<=0, `clk_out` toggles; else `cnt`++.
- Period boundary = `cnt`==`active` with `clk_out`=0. At the boundary: apply `pend` (as above); if `en`=0 go IDLE (`clk_out` stays 0, no tick); else `clk_out`<=1, `tick`<=1.
- Result: output period 2(D+1) cycles, 50 % duty; D=0 gives period 2.
- `en` sampled only in IDLE and at boundaries; changes mid-period never shorten a phase.
- Channels are fully independent; simultaneous boundaries on several channels are all honoured on the same edge.

## Timing
- Reset (async assert, immediate): `clk_out`=0, `tick`=0, `cnt`=0, all channels IDLE, `active`=`pending`=`RST_DIV`, `pend`=0, `div_ready`=1.
- `en` 0->1 in IDLE, sampled at edge k: `clk_out`=1, `tick`=1 after edge k.
- `tick` high exactly one cycle per period.
- Accepted write to a RUN channel: `div_ready` for that channel low from next cycle until one cycle after the boundary that applies it; latency <= 2(D_old+1) cycles.
- Reset mid-period: all state cleared immediately, no partial pulse on `tick`.

## Configuration
- `ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN` defined: deferred, boundary-aligned updates as above.
- Not defined: no pending slot; `div_ready` tied 1; an accepted write sets `active` directly; a RUN channel restarts in low phase on the next edge (`clk_out`=0, `cnt`=0), first rise D_new+1 cycles later. IDLE/`en` behaviour unchanged.

## Test plan
- Reset release, `en`=2'b01, `RST_DIV`=0 -> ch0 `clk_out` 1,0,1,0… from first edge, `tick` every 2 cycles; ch1 `clk_out`=0, `tick`=0 throughout.
- ch0 running D=0, write ch0 D=3 -> `div_ready` low for ch0 until the next boundary, then 4 high / 4 low repeating; no phase shorter than 1 cycle before switch.
- ch0 pending, write ch1 D=1 same/next cycle -> ch1 accepted (`div_ready`=1 at `div_chan`=1), ch1 period 4; ch0 unaffected.
- ch0 D=3, drop `en[0]` 1 cycle into high phase -> high phase lasts 4 cycles, low phase 4 cycles, then idle low; exactly one more `tick`, none after.
- Assert `rst` mid high phase between edges -> `clk_out`, `tick` 0 before next `clk` edge; after release with `en`=1, period 2(`RST_DIV`+1).
- Macro undefined: ch0 D=0 running, write D=5 -> `clk_out`=0 next cycle, rises 6 cycles later, period 12; `div_ready` always 1.

Source files
------------

// File: rtl/adam_clk_div_prog_if.sv
// Divisor write port of the programmable multi-channel clock divider.
interface adam_clk_div_prog_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2
);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             div_valid;
  logic             div_ready;
  logic [CW-1:0]    div_chan;
  logic [WIDTH-1:0] div_value;

  modport master (output div_valid, output div_chan, output div_value, input div_ready);
  modport slave  (input div_valid, input div_chan, input div_value, output div_ready);
endinterface

// File: rtl/adam_clk_div_prog.sv
// Runtime-programmable multi-channel clock divider with per-channel enable and tick.
// ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN selects boundary-aligned divisor updates.
module adam_clk_div_prog #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned RST_DIV  = 0
) (
  input  logic                clk,
  input  logic                rst,
  adam_clk_div_prog_if.slave  div,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick
);
  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t              state_q  [CHANNELS];
  state_t              state_d  [CHANNELS];
  logic [WIDTH-1:0]    cnt_q    [CHANNELS];
  logic [WIDTH-1:0]    cnt_d    [CHANNELS];
  logic [WIDTH-1:0]    active_q [CHANNELS];
  logic [WIDTH-1:0]    active_d [CHANNELS];
  logic [CHANNELS-1:0] clk_q, clk_d, tick_q, tick_d, wr_hit;
  logic                ready_c;
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
  logic [WIDTH-1:0]    pending_q [CHANNELS];
  logic [WIDTH-1:0]    pending_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
`endif

  // Write decode; out-of-range channels are always ready and match no slot.
  always_comb begin
    ready_c = 1'b1;
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (div.div_chan == CW'(c)) ready_c = !pend_q[c];
    end
`endif
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      wr_hit[c] = div.div_valid && ready_c && (div.div_chan == CW'(c));
    end
  end

  assign div.div_ready = ready_c;

  // Per-channel next-state and output logic.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      state_d[c]  = state_q[c];
      cnt_d[c]    = cnt_q[c];
      active_d[c] = active_q[c];
      clk_d[c]    = clk_q[c];
      tick_d[c]   = 1'b0;
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
      pending_d[c] = pending_q[c];
      pend_d[c]    = pend_q[c];
      if (wr_hit[c]) begin
        pending_d[c] = div.div_value;
        pend_d[c]    = 1'b1;
      end
`else
      if (wr_hit[c]) active_d[c] = div.div_value;
`endif
      case (state_q[c])
        IDLE: begin
          cnt_d[c] = '0;
          clk_d[c] = 1'b0;
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
          if (pend_q[c]) begin
            active_d[c] = pending_q[c];
            pend_d[c]   = 1'b0;
          end
`endif
          if (en[c]) begin
            state_d[c] = RUN;
            clk_d[c]   = 1'b1;
            tick_d[c]  = 1'b1;
          end
        end
        RUN: begin
`ifndef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
          // Immediate update: restart in the low phase with the new divisor.
          if (wr_hit[c]) begin
            cnt_d[c] = '0;
            clk_d[c] = 1'b0;
          end else
`endif
          if (cnt_q[c] == active_q[c]) begin
            cnt_d[c] = '0;
            if (clk_q[c]) begin
              clk_d[c] = 1'b0;
            end else begin
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
              if (pend_q[c]) begin
                active_d[c] = pending_q[c];
                pend_d[c]   = 1'b0;
              end
`endif
              if (en[c]) begin
                clk_d[c]  = 1'b1;
                tick_d[c] = 1'b1;
              end else begin
                state_d[c] = IDLE;
              end
            end
          end else begin
            cnt_d[c] = cnt_q[c] + WIDTH'(1);
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= IDLE;
        cnt_q[c]    <= '0;
        active_q[c] <= WIDTH'(RST_DIV);
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
        pending_q[c] <= WIDTH'(RST_DIV);
`endif
      end
      clk_q  <= '0;
      tick_q <= '0;
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
      pend_q <= '0;
`endif
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        state_q[c]  <= state_d[c];
        cnt_q[c]    <= cnt_d[c];
        active_q[c] <= active_d[c];
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
        pending_q[c] <= pending_d[c];
`endif
      end
      clk_q  <= clk_d;
      tick_q <= tick_d;
`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
      pend_q <= pend_d;
`endif
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
endmodule

// File: tb/tb_adam_clk_div_prog.sv
// Directed bench for adam_clk_div_prog (WIDTH=8, CHANNELS=2, RST_DIV=0).
module tb_adam_clk_div_prog;
  localparam int unsigned WIDTH    = 8;
  localparam int unsigned CHANNELS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] en  = 2'b00;
  wire  [1:0] clk_out;
  wire  [1:0] tick;

  int n_tests = 0;
  int n_fail  = 0;

  adam_clk_div_prog_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) div_if ();

  adam_clk_div_prog #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .RST_DIV(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .div     (div_if),
    .en      (en),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic found;
    logic exp_clk, exp_tick;
    div_if.div_valid = 1'b0;
    div_if.div_chan  = '0;
    div_if.div_value = '0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #2;
    check("rst clk_out", 32'(clk_out), 32'd0);
    check("rst tick", 32'(tick), 32'd0);
    check("rst ready", 32'(div_if.div_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    en  = 2'b01;

    // RST_DIV=0: ch0 toggles every cycle from the first edge, ch1 stays low.
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("init ch0 clk i=%0d", i), 32'(clk_out[0]), 32'(i % 2));
      check($sformatf("init ch0 tick i=%0d", i), 32'(tick[0]), 32'(i % 2));
      check($sformatf("init ch1 i=%0d", i), 32'({clk_out[1], tick[1]}), 32'd0);
    end

`ifdef ADAM_CLK_DIV_PROG_SAFE_UPDATE_EN
    // Deferred update of ch0 to D=3; ch1 written while ch0 is pending.
    div_if.div_valid = 1'b1;
    div_if.div_chan  = 1'b0;
    div_if.div_value = 8'd3;
    #1 check("safe wr0 ready", 32'(div_if.div_ready), 32'd1);
    step();
    div_if.div_valid = 1'b0;
    check("safe i=0 clk", 32'(clk_out[0]), 32'd1);
    check("safe i=0 tick", 32'(tick[0]), 32'd1);
    check("safe i=0 ready ch0", 32'(div_if.div_ready), 32'd0);
    div_if.div_chan  = 1'b1;
    div_if.div_value = 8'd1;
    div_if.div_valid = 1'b1;
    #1 check("safe ready ch1", 32'(div_if.div_ready), 32'd1);
    step();
    div_if.div_valid = 1'b0;
    div_if.div_chan  = 1'b0;
    #1;
    for (int i = 1; i <= 21; i++) begin
      if (i > 1) step();
      exp_clk  = (i == 1) ? 1'b0 : (((i - 2) / 4) % 2 == 0);
      exp_tick = (i >= 2) && ((i - 2) % 8 == 0);
      check($sformatf("safe ch0 clk i=%0d", i), 32'(clk_out[0]), 32'(exp_clk));
      check($sformatf("safe ch0 tick i=%0d", i), 32'(tick[0]), 32'(exp_tick));
      check($sformatf("safe ch0 ready i=%0d", i), 32'(div_if.div_ready), 32'(i >= 2));
    end
`else
    // Immediate update of ch0 to D=5: restart low, first rise 6 cycles later.
    div_if.div_valid = 1'b1;
    div_if.div_chan  = 1'b0;
    div_if.div_value = 8'd5;
    #1 check("imm wr0 ready", 32'(div_if.div_ready), 32'd1);
    step();
    div_if.div_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) step();
      exp_clk  = (i >= 6) && (((i - 6) / 6) % 2 == 0);
      exp_tick = (i >= 6) && ((i - 6) % 12 == 0);
      check($sformatf("imm ch0 clk i=%0d", i), 32'(clk_out[0]), 32'(exp_clk));
      check($sformatf("imm ch0 tick i=%0d", i), 32'(tick[0]), 32'(exp_tick));
      check($sformatf("imm ready i=%0d", i), 32'(div_if.div_ready), 32'd1);
    end
    div_if.div_valid = 1'b1;
    div_if.div_chan  = 1'b1;
    div_if.div_value = 8'd1;
    #1 check("imm wr1 ready", 32'(div_if.div_ready), 32'd1);
    step();
    div_if.div_valid = 1'b0;
    div_if.div_chan  = 1'b0;
`endif
    check("ch1 idle clk", 32'(clk_out[1]), 32'd0);
    step();
    check("ch1 idle clk 2", 32'(clk_out[1]), 32'd0);

    // ch1 with D=1: period 4, then drop en one cycle into a high phase.
    en = 2'b11;
    for (int i = 0; i <= 9; i++) begin
      step();
      check($sformatf("ch1 clk i=%0d", i), 32'(clk_out[1]), 32'(((i / 2) % 2) == 0));
      check($sformatf("ch1 tick i=%0d", i), 32'(tick[1]), 32'((i % 4) == 0));
    end
    en = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("ch1 drop clk i=%0d", i), 32'(clk_out[1]), 32'd0);
      check($sformatf("ch1 drop tick i=%0d", i), 32'(tick[1]), 32'd0);
    end

    // Reset asserted between edges during a ch0 high phase.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = clk_out[0];
    end
    check("rst wait high", 32'(found), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst clk_out", 32'(clk_out), 32'd0);
    check("midrst tick", 32'(tick), 32'd0);
    check("midrst ready", 32'(div_if.div_ready), 32'd1);
    step();
    check("midrst hold", 32'({clk_out, tick}), 32'd0);
    rst = 1'b0;
    en  = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("post rst clk i=%0d", i), 32'(clk_out[0]), 32'(i % 2));
      check($sformatf("post rst tick i=%0d", i), 32'(tick[0]), 32'(i % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
